eva_axi_rd_arb: RTL and testbench

//  Round-robin arbiter that shares one 128-bit AXI4 read port (AR + R channels) among NUM_REQ

---
 rtl/eva_arb_pkg.sv | 12 +
 rtl/eva_rr_pick.sv | 39 +++
 rtl/eva_axi_rd_arb.sv | 201 ++++++++++++++++++++
 tb/tb_eva_axi_rd_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eva_arb_pkg.sv
// rtl/eva_arb_pkg.sv - shared widths, AXI constants and FSM state type for the read arbiter
package eva_arb_pkg;
    localparam int EVA_AXI_ADDR_W = 32;
    localparam int EVA_AXI_DATA_W = 128;
    localparam int EVA_AXI_ID_W   = 4;
    localparam int EVA_AXI_LEN_W  = 6;

    localparam logic [2:0] EVA_AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] EVA_AXI_BURST_INCR = 2'b01;

    typedef enum logic {ARB_IDLE, ARB_ADDR} arb_state_t;
endpackage

// File: rtl/eva_rr_pick.sv
// rtl/eva_rr_pick.sv - combinational round-robin picker: first set req at or after ptr, wrapping
module eva_rr_pick
    import eva_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]      req,
    input  logic [EVA_AXI_ID_W-1:0] ptr,
    output logic [EVA_AXI_ID_W-1:0] gnt,
    output logic                    any
);

    always_comb begin
        int  idx;
        logic hit;
        gnt = '0;
        any = 1'b0;
        idx = 0;
        hit = 1'b0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            hit = 1'b0;
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == idx) begin
                    hit = req[j];
                end
            end
            if (hit) begin
                gnt = idx[EVA_AXI_ID_W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eva_axi_rd_arb.sv
// rtl/eva_axi_rd_arb.sv - round-robin AXI4 read arbiter with per-requester outstanding caps
// Optional grant statistics when EVA_RD_ARB_STAT_EN is defined.
module eva_axi_rd_arb
    import eva_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_OUTS = 4
) (
    input  logic                        aclk,
    input  logic                        arest_n,
    input  logic [NUM_REQ-1:0]          s_arvalid,
    input  logic [NUM_REQ*32-1:0]       s_araddr,
    input  logic [NUM_REQ*6-1:0]        s_arlen,
    output logic [NUM_REQ-1:0]          s_arready,
    output logic [NUM_REQ-1:0]          s_rvalid,
    output logic [EVA_AXI_DATA_W-1:0]   s_rdata,
    output logic                        s_rlast,
    output logic [1:0]                  s_rresp,
    input  logic [NUM_REQ-1:0]          s_rready,
    output logic                        m_arvalid,
    output logic [EVA_AXI_ID_W-1:0]     m_arid,
    output logic [EVA_AXI_ADDR_W-1:0]   m_araddr,
    output logic [EVA_AXI_LEN_W-1:0]    m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [1:0]                  m_arburst,
    input  logic                        m_arready,
    input  logic                        m_rvalid,
    input  logic [EVA_AXI_ID_W-1:0]     m_rid,
    input  logic [EVA_AXI_DATA_W-1:0]   m_rdata,
    input  logic                        m_rlast,
    input  logic [1:0]                  m_rresp,
    output logic                        m_rready,
    output logic                        err_rid
`ifdef EVA_RD_ARB_STAT_EN
    ,
    input  logic [3:0]                  stat_sel,
    output logic [15:0]                 stat_cnt
`endif
);

    localparam int CNT_W = 4;

    arb_state_t              state_q, state_d;
    logic [EVA_AXI_ID_W-1:0] gnt_q, gnt_d;
    logic [EVA_AXI_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]        out_cnt_q [NUM_REQ];
    logic [CNT_W-1:0]        out_cnt_d [NUM_REQ];
    logic                    err_rid_q, err_rid_d;

    logic [NUM_REQ-1:0]      elig;
    logic [NUM_REQ-1:0]      inc_v;
    logic [NUM_REQ-1:0]      dec_v;
    logic [EVA_AXI_ID_W-1:0] pick_gnt;
    logic                    pick_any;
    logic                    ar_hs;
    logic                    r_hs;
    logic                    rid_ok;
    logic                    rid_cnt_zero;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = s_arvalid[i] && (out_cnt_q[i] < CNT_W'(MAX_OUTS));
        end
    end

    eva_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (elig),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    assign m_arvalid = (state_q == ARB_ADDR);
    assign m_arid    = gnt_q;
    assign m_arsize  = EVA_AXI_SIZE_16B;
    assign m_arburst = EVA_AXI_BURST_INCR;
    assign ar_hs     = m_arvalid && m_arready;

    always_comb begin
        m_araddr  = '0;
        m_arlen   = '0;
        s_arready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q == EVA_AXI_ID_W'(i)) begin
                m_araddr     = s_araddr[32*i +: 32];
                m_arlen      = s_arlen[6*i +: 6];
                s_arready[i] = ar_hs;
            end
        end
    end

    // Out-of-range ids are always accepted so a stray beat cannot stall the bus.
    always_comb begin
        m_rready     = 1'b1;
        rid_ok       = 1'b0;
        rid_cnt_zero = 1'b1;
        s_rvalid     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_rid == EVA_AXI_ID_W'(i)) begin
                m_rready     = s_rready[i];
                rid_ok       = 1'b1;
                rid_cnt_zero = (out_cnt_q[i] == '0);
                s_rvalid[i]  = m_rvalid;
            end
        end
    end

    assign s_rdata = m_rdata;
    assign s_rlast = m_rlast;
    assign s_rresp = m_rresp;
    assign r_hs    = m_rvalid && m_rready;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            inc_v[i]     = ar_hs && (gnt_q == EVA_AXI_ID_W'(i));
            dec_v[i]     = r_hs && m_rlast && (m_rid == EVA_AXI_ID_W'(i)) && (out_cnt_q[i] != '0);
            out_cnt_d[i] = out_cnt_q[i];
            if (inc_v[i] && !dec_v[i]) begin
                out_cnt_d[i] = out_cnt_q[i] + 1'b1;
            end else if (dec_v[i] && !inc_v[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - 1'b1;
            end
        end
        err_rid_d = err_rid_q || (r_hs && (!rid_ok || rid_cnt_zero));
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == ARB_IDLE) begin
            if (pick_any) begin
                gnt_d   = pick_gnt;
                state_d = ARB_ADDR;
            end
        end else begin
            if (m_arready) begin
                state_d  = ARB_IDLE;
                rr_ptr_d = (gnt_q == EVA_AXI_ID_W'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state_q   <= ARB_IDLE;
            gnt_q     <= '0;
            rr_ptr_q  <= '0;
            err_rid_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                out_cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            rr_ptr_q  <= rr_ptr_d;
            err_rid_q <= err_rid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                out_cnt_q[i] <= out_cnt_d[i];
            end
        end
    end

    assign err_rid = err_rid_q;

`ifdef EVA_RD_ARB_STAT_EN
    logic [15:0] stat_q [NUM_REQ];
    logic [15:0] stat_d [NUM_REQ];
    logic [15:0] stat_cnt_q, stat_cnt_d;

    always_comb begin
        stat_cnt_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_d[i] = stat_q[i];
            if (inc_v[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_d[i] = stat_q[i] + 16'd1;
            end
            if (stat_sel == 4'(i)) begin
                stat_cnt_d = stat_q[i];
            end
        end
    end

    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            stat_cnt_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            stat_cnt_q <= stat_cnt_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                stat_q[i] <= stat_d[i];
            end
        end
    end

    assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_eva_axi_rd_arb.sv
// tb/tb_eva_axi_rd_arb.sv - directed self-checking bench for eva_axi_rd_arb
module tb_eva_axi_rd_arb;
    localparam int NUM_REQ  = 4;
    localparam int MAX_OUTS = 4;

    logic                  aclk = 1'b0;
    logic                  arest_n;
    logic [NUM_REQ-1:0]    s_arvalid;
    logic [NUM_REQ*32-1:0] s_araddr;
    logic [NUM_REQ*6-1:0]  s_arlen;
    logic [NUM_REQ-1:0]    s_arready;
    logic [NUM_REQ-1:0]    s_rvalid;
    logic [127:0]          s_rdata;
    logic                  s_rlast;
    logic [1:0]            s_rresp;
    logic [NUM_REQ-1:0]    s_rready;
    logic                  m_arvalid;
    logic [3:0]            m_arid;
    logic [31:0]           m_araddr;
    logic [5:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;
    logic                  m_arready;
    logic                  m_rvalid;
    logic [3:0]            m_rid;
    logic [127:0]          m_rdata;
    logic                  m_rlast;
    logic [1:0]            m_rresp;
    logic                  m_rready;
    logic                  err_rid;
`ifdef EVA_RD_ARB_STAT_EN
    logic [3:0]            stat_sel;
    logic [15:0]           stat_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 aclk = ~aclk;

    eva_axi_rd_arb #(.NUM_REQ(NUM_REQ), .MAX_OUTS(MAX_OUTS)) dut (
        .aclk      (aclk),
        .arest_n   (arest_n),
        .s_arvalid (s_arvalid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arready (s_arready),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata),
        .s_rlast   (s_rlast),
        .s_rresp   (s_rresp),
        .s_rready  (s_rready),
        .m_arvalid (m_arvalid),
        .m_arid    (m_arid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arburst (m_arburst),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rid     (m_rid),
        .m_rdata   (m_rdata),
        .m_rlast   (m_rlast),
        .m_rresp   (m_rresp),
        .m_rready  (m_rready),
        .err_rid   (err_rid)
`ifdef EVA_RD_ARB_STAT_EN
        ,
        .stat_sel  (stat_sel),
        .stat_cnt  (stat_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        arest_n   = 1'b0;
        s_arvalid = '0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_rready  = '1;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rid     = '0;
        m_rdata   = '0;
        m_rlast   = 1'b0;
        m_rresp   = '0;
`ifdef EVA_RD_ARB_STAT_EN
        stat_sel  = '0;
`endif
        tick();
        tick();
        arest_n = 1'b1;
    endtask

    int g_id[$];
    int g_cyc[$];
    int hs;
    logic found;

    initial begin
        // 1: single requester, one 4-beat burst
        do_reset();
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_arready", s_arready, 4'b0000);
        chk("rst_err", err_rid, 1'b0);
        chk("rst_cnt0", dut.out_cnt_q[0], 4'd0);
        s_arvalid[0]     = 1'b1;
        s_araddr[31:0]   = 32'h0000_1000;
        s_arlen[5:0]     = 6'd3;
        m_arready        = 1'b1;
        #1;
        chk("t1_no_arvalid_n", m_arvalid, 1'b0);
        tick();
        chk("t1_arvalid", m_arvalid, 1'b1);
        chk("t1_arid", m_arid, 4'd0);
        chk("t1_araddr", m_araddr, 32'h0000_1000);
        chk("t1_arlen", m_arlen, 6'd3);
        chk("t1_arsize", m_arsize, 3'b100);
        chk("t1_arburst", m_arburst, 2'b01);
        chk("t1_s_arready", s_arready, 4'b0001);
        tick();
        s_arvalid = '0;
        chk("t1_cnt_one", dut.out_cnt_q[0], 4'd1);
        for (int b = 0; b < 4; b++) begin
            m_rvalid = 1'b1;
            m_rid    = 4'd0;
            m_rdata  = {96'h0, 32'hBEEF_0000 + 32'(b)};
            m_rlast  = (b == 3);
            #1;
            chk("t1_s_rvalid", s_rvalid, 4'b0001);
            chk("t1_rdata", s_rdata, {96'h0, 32'hBEEF_0000 + 32'(b)});
            tick();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        chk("t1_cnt_zero", dut.out_cnt_q[0], 4'd0);
        chk("t1_err", err_rid, 1'b0);

        // 2: all requesters, round-robin order, one AR every 2 cycles
        do_reset();
        s_arvalid = 4'b1111;
        m_arready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (m_arvalid) begin
                g_id.push_back(int'(m_arid));
                g_cyc.push_back(c);
            end
        end
        s_arvalid = '0;
        chk("t2_grant_count_ge5", (g_id.size() >= 5), 1'b1);
        if (g_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk("t2_order", g_id[k], k % 4);
            end
            for (int k = 1; k < 5; k++) begin
                chk("t2_spacing", g_cyc[k] - g_cyc[k-1], 2);
            end
        end

        // 3: outstanding cap at MAX_OUTS, release after one rlast
        do_reset();
        s_arvalid[1]    = 1'b1;
        s_araddr[63:32] = 32'h0000_4000;
        m_arready       = 1'b1;
        hs = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (m_arvalid && s_arready[1]) hs++;
        end
        chk("t3_hs_capped", hs, MAX_OUTS);
        chk("t3_cnt_max", dut.out_cnt_q[1], 4'd4);
        chk("t3_blocked", m_arvalid, 1'b0);
        m_rvalid = 1'b1;
        m_rid    = 4'd1;
        m_rlast  = 1'b1;
        tick();
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        chk("t3_cnt_dec", dut.out_cnt_q[1], 4'd3);
        found = 1'b0;
        for (int c = 0; c < 4 && !found; c++) begin
            tick();
            if (m_arvalid && m_arid == 4'd1) found = 1'b1;
        end
        chk("t3_regrant", found, 1'b1);
        tick();
        s_arvalid = '0;
        chk("t3_cnt_back", dut.out_cnt_q[1], 4'd4);

        // 4: stalled AR holds grant, payload and pointer
        do_reset();
        s_arvalid        = 4'b1100;
        s_araddr[95:64]  = 32'h2222_0000;
        s_araddr[127:96] = 32'h3333_0000;
        tick();
        for (int c = 0; c < 10; c++) begin
            chk("t4_hold", {m_arvalid, m_arid, m_araddr}, {1'b1, 4'd2, 32'h2222_0000});
            chk("t4_ptr_hold", dut.rr_ptr_q, 4'd0);
            tick();
        end
        m_arready = 1'b1;
        #1;
        chk("t4_s_arready", s_arready, 4'b0100);
        tick();
        s_arvalid[2] = 1'b0;
        chk("t4_ptr_upd", dut.rr_ptr_q, 4'd3);
        tick();
        chk("t4_next_gnt", {m_arvalid, m_arid, m_araddr}, {1'b1, 4'd3, 32'h3333_0000});
        tick();
        s_arvalid = '0;

        // 5: stray rid and same-cycle inc/dec
        do_reset();
        s_rready = '0;
        m_rvalid = 1'b1;
        m_rid    = 4'd7;
        #1;
        chk("t5_rready_drop", m_rready, 1'b1);
        chk("t5_no_rvalid", s_rvalid, 4'b0000);
        tick();
        m_rvalid = 1'b0;
        chk("t5_err_set", err_rid, 1'b1);
        tick();
        tick();
        tick();
        chk("t5_err_sticky", err_rid, 1'b1);
        s_rready     = '1;
        s_arvalid[2] = 1'b1;
        m_arready    = 1'b1;
        tick();
        tick();
        chk("t5_cnt2_one", dut.out_cnt_q[2], 4'd1);
        tick();
        chk("t5_addr_again", {m_arvalid, m_arid}, {1'b1, 4'd2});
        m_rvalid = 1'b1;
        m_rid    = 4'd2;
        m_rlast  = 1'b1;
        tick();
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        s_arvalid = '0;
        chk("t5_cnt2_same", dut.out_cnt_q[2], 4'd1);
        chk("t5_err_still", err_rid, 1'b1);

        // 6: asynchronous reset in ADDR with outstanding bursts
        do_reset();
        s_arvalid[0] = 1'b1;
        m_arready    = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        m_arready = 1'b0;
        tick();
        chk("t6_in_addr", m_arvalid, 1'b1);
        chk("t6_cnt3", dut.out_cnt_q[0], 4'd3);
`ifdef EVA_RD_ARB_STAT_EN
        chk("t6_stat_pre", stat_cnt, 16'd3);
`endif
        #2;
        arest_n = 1'b0;
        #1;
        chk("t6_arvalid_low", m_arvalid, 1'b0);
        chk("t6_cnt_clr", dut.out_cnt_q[0], 4'd0);
        chk("t6_arready_low", s_arready, 4'b0000);
`ifdef EVA_RD_ARB_STAT_EN
        chk("t6_stat_clr", stat_cnt, 16'd0);
`endif
        tick();
        arest_n   = 1'b1;
        s_arvalid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
